// File: rtl/axi4l_reg_slave.sv
// AXI4-Lite register slave: NUM_REGS x DATA_WIDTH read/write registers mirrored onto reg_out.
// Latency: write response and read data one cycle after the completing address/data handshake.
// Backpressure: one outstanding write and one outstanding read; ready drops while a response waits.
// Optional build macro AXI4L_REG_SLAVE_DECERR_EN: out-of-range accesses answer DECERR instead of OKAY.
module axi4l_reg_slave #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 16
) (
   input  logic                           axi4l_aclk,
   input  logic                           axi4l_arst,
   input  logic [ADDR_WIDTH-1:0]          awaddr,
   input  logic                           awvalid,
   output logic                           awready,
   input  logic [DATA_WIDTH-1:0]          wdata,
   input  logic [DATA_WIDTH/8-1:0]        wstrb,
   input  logic                           wvalid,
   output logic                           wready,
   output logic [1:0]                     bresp,
   output logic                           bvalid,
   input  logic                           bready,
   input  logic [ADDR_WIDTH-1:0]          araddr,
   input  logic                           arvalid,
   output logic                           arready,
   output logic [DATA_WIDTH-1:0]          rdata,
   output logic [1:0]                     rresp,
   output logic                           rvalid,
   input  logic                           rready,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
   output logic [NUM_REGS-1:0]            reg_wr
);

   localparam int STRB_W   = DATA_WIDTH / 8;
   localparam int ADDR_LSB = $clog2(STRB_W);
   localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;

   localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI4L_REG_SLAVE_DECERR_EN
   localparam logic [1:0] RESP_OOR  = 2'b11;
`else
   localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

   typedef enum logic {W_IDLE, W_RESP} wstate_t;
   typedef enum logic {R_IDLE, R_DATA} rstate_t;

   wstate_t r_wstate, w_wstate_nxt;
   rstate_t r_rstate, w_rstate_nxt;

   logic                  r_aw_held;
   logic                  r_w_held;
   logic [IDX_W-1:0]      r_awidx;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [STRB_W-1:0]     r_wstrb;
   logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
   logic [NUM_REGS-1:0]   r_reg_wr;
   logic [1:0]            r_bresp;
   logic [1:0]            r_rresp;
   logic [DATA_WIDTH-1:0] r_rdata;

   logic                  w_aw_fire;
   logic                  w_w_fire;
   logic                  w_ar_fire;
   logic                  w_commit;
   logic [IDX_W-1:0]      w_awidx;
   logic [IDX_W-1:0]      w_widx;
   logic [DATA_WIDTH-1:0] w_cm_data;
   logic [STRB_W-1:0]     w_cm_strb;
   logic                  w_wr_in;
   logic [IDX_W-1:0]      w_ridx;
   logic                  w_rd_in;
   logic [DATA_WIDTH-1:0] w_rd_mux;
   logic                  w_unused_addr_lsb;

   // Byte-offset bits never select anything; fold them away explicitly.
   assign w_unused_addr_lsb = ^{awaddr[ADDR_LSB-1:0], araddr[ADDR_LSB-1:0]};

   assign bvalid  = (r_wstate == W_RESP);
   assign rvalid  = (r_rstate == R_DATA);
   assign awready = !r_aw_held && !bvalid;
   assign wready  = !r_w_held && !bvalid;
   assign arready = !rvalid;
   assign bresp   = r_bresp;
   assign rresp   = r_rresp;
   assign rdata   = r_rdata;
   assign reg_wr  = r_reg_wr;

   assign w_aw_fire = awvalid && awready;
   assign w_w_fire  = wvalid && wready;
   assign w_ar_fire = arvalid && arready;

   // A write commits on the edge where both halves are available, held or arriving now.
   assign w_commit  = (r_aw_held || w_aw_fire) && (r_w_held || w_w_fire);
   assign w_awidx   = awaddr[ADDR_WIDTH-1:ADDR_LSB];
   assign w_widx    = r_aw_held ? r_awidx : w_awidx;
   assign w_cm_data = r_w_held ? r_wdata : wdata;
   assign w_cm_strb = r_w_held ? r_wstrb : wstrb;
   assign w_wr_in   = (w_widx < IDX_W'(NUM_REGS));

   assign w_ridx    = araddr[ADDR_WIDTH-1:ADDR_LSB];
   assign w_rd_in   = (w_ridx < IDX_W'(NUM_REGS));

   // Flatten the register file onto the fabric-facing bus.
   genvar g;
   generate
      for (g = 0; g < NUM_REGS; g++) begin : g_reg_out
         assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
      end
   endgenerate

   // Read-data mux; out-of-range indices fall through to zero.
   always_comb begin
      w_rd_mux = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (w_ridx == IDX_W'(i)) begin
            w_rd_mux = r_regs[i];
         end
      end
   end

   // Write and read channel state registers.
   always_ff @(posedge axi4l_aclk or posedge axi4l_arst) begin
      if (axi4l_arst) begin
         r_wstate <= W_IDLE;
         r_rstate <= R_IDLE;
      end else begin
         r_wstate <= w_wstate_nxt;
         r_rstate <= w_rstate_nxt;
      end
   end

   // Next-state logic for both channels.
   always_comb begin
      w_wstate_nxt = r_wstate;
      w_rstate_nxt = r_rstate;
      case (r_wstate)
         W_IDLE:  if (w_commit) w_wstate_nxt = W_RESP;
         W_RESP:  if (bready)   w_wstate_nxt = W_IDLE;
         default: w_wstate_nxt = W_IDLE;
      endcase
      case (r_rstate)
         R_IDLE:  if (w_ar_fire) w_rstate_nxt = R_DATA;
         R_DATA:  if (rready)    w_rstate_nxt = R_IDLE;
         default: w_rstate_nxt = R_IDLE;
      endcase
   end

   // Capture AW and W independently and hold them until the pair is complete.
   always_ff @(posedge axi4l_aclk or posedge axi4l_arst) begin
      if (axi4l_arst) begin
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_awidx   <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
      end else if (w_commit) begin
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
      end else begin
         if (w_aw_fire) begin
            r_aw_held <= 1'b1;
            r_awidx   <= w_awidx;
         end
         if (w_w_fire) begin
            r_w_held <= 1'b1;
            r_wdata  <= wdata;
            r_wstrb  <= wstrb;
         end
      end
   end

   // Register file update with byte strobes and a one-cycle write pulse.
   always_ff @(posedge axi4l_aclk or posedge axi4l_arst) begin
      if (axi4l_arst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
         r_reg_wr <= '0;
      end else begin
         r_reg_wr <= '0;
         if (w_commit && w_wr_in) begin
            for (int i = 0; i < NUM_REGS; i++) begin
               if (w_widx == IDX_W'(i)) begin
                  r_reg_wr[i] <= 1'b1;
                  for (int b = 0; b < STRB_W; b++) begin
                     if (w_cm_strb[b]) begin
                        r_regs[i][8*b +: 8] <= w_cm_data[8*b +: 8];
                     end
                  end
               end
            end
         end
      end
   end

   // Write response code, fixed at commit and held until accepted.
   always_ff @(posedge axi4l_aclk or posedge axi4l_arst) begin
      if (axi4l_arst) begin
         r_bresp <= RESP_OKAY;
      end else if (w_commit) begin
         r_bresp <= w_wr_in ? RESP_OKAY : RESP_OOR;
      end
   end

   // Read data and response, sampled at the AR handshake from pre-write register contents.
   always_ff @(posedge axi4l_aclk or posedge axi4l_arst) begin
      if (axi4l_arst) begin
         r_rdata <= '0;
         r_rresp <= RESP_OKAY;
      end else if (w_ar_fire) begin
         r_rdata <= w_rd_mux;
         r_rresp <= w_rd_in ? RESP_OKAY : RESP_OOR;
      end
   end

endmodule

// File: tb/tb_axi4l_reg_slave.sv
// Randomized and directed bench for axi4l_reg_slave against a transaction-level register model.
// The model tracks pending AW/W halves, outstanding responses and register contents as plain arrays.
// Every cycle outside reset, all DUT outputs are compared against the model.
module tb_axi4l_reg_slave;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [31:0]  awaddr = '0;
   logic         awvalid = 1'b0;
   logic         awready;
   logic [31:0]  wdata = '0;
   logic [3:0]   wstrb = '0;
   logic         wvalid = 1'b0;
   logic         wready;
   logic [1:0]   bresp;
   logic         bvalid;
   logic         bready = 1'b1;
   logic [31:0]  araddr = '0;
   logic         arvalid = 1'b0;
   logic         arready;
   logic [31:0]  rdata;
   logic [1:0]   rresp;
   logic         rvalid;
   logic         rready = 1'b1;
   logic [511:0] reg_out;
   logic [15:0]  reg_wr;

`ifdef AXI4L_REG_SLAVE_DECERR_EN
   localparam logic [1:0] EXP_OOR = 2'b11;
`else
   localparam logic [1:0] EXP_OOR = 2'b00;
`endif

   int n_checks = 0;
   int n_errors = 0;

   axi4l_reg_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16)) dut (
      .axi4l_aclk(clk), .axi4l_arst(rst),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .reg_out(reg_out), .reg_wr(reg_wr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_regs [16];
   bit          m_aw_pend, m_w_pend, m_bvalid, m_rvalid;
   logic [31:0] m_awaddr, m_wdata, m_rdata;
   logic [3:0]  m_wstrb;
   logic [1:0]  m_bresp, m_rresp;
   logic [15:0] m_reg_wr;
   bit          f_aw, f_w, f_ar;

   always @(posedge clk or posedge rst) begin
      int unsigned idx;
      if (rst) begin
         for (int i = 0; i < 16; i++) m_regs[i] = '0;
         m_aw_pend = 0; m_w_pend = 0; m_bvalid = 0; m_rvalid = 0;
         m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = '0; m_reg_wr = '0;
         f_aw = 0; f_w = 0; f_ar = 0;
      end else begin
         f_aw = awvalid && !m_aw_pend && !m_bvalid;
         f_w  = wvalid && !m_w_pend && !m_bvalid;
         f_ar = arvalid && !m_rvalid;
         m_reg_wr = '0;
         // read side sees register contents before any write of this edge
         if (m_rvalid && rready) m_rvalid = 0;
         if (f_ar) begin
            idx = araddr / 4;
            m_rdata  = (idx < 16) ? m_regs[idx] : 32'h0;
            m_rresp  = (idx < 16) ? 2'b00 : EXP_OOR;
            m_rvalid = 1;
         end
         if (m_bvalid && bready) m_bvalid = 0;
         if (f_aw) begin m_aw_pend = 1; m_awaddr = awaddr; end
         if (f_w)  begin m_w_pend = 1; m_wdata = wdata; m_wstrb = wstrb; end
         if (m_aw_pend && m_w_pend) begin
            idx = m_awaddr / 4;
            if (idx < 16) begin
               for (int b = 0; b < 4; b++)
                  if (m_wstrb[b]) m_regs[idx][8*b +: 8] = m_wdata[8*b +: 8];
               m_reg_wr[idx] = 1'b1;
               m_bresp = 2'b00;
            end else begin
               m_bresp = EXP_OOR;
            end
            m_bvalid = 1; m_aw_pend = 0; m_w_pend = 0;
         end
      end
   end

   // Per-cycle comparison of every DUT output against the model.
   always @(negedge clk) begin
      if (!rst) begin
         chk("awready", awready, !m_aw_pend && !m_bvalid);
         chk("wready",  wready,  !m_w_pend && !m_bvalid);
         chk("arready", arready, !m_rvalid);
         chk("bvalid",  bvalid,  m_bvalid);
         chk("rvalid",  rvalid,  m_rvalid);
         if (m_bvalid) chk("bresp", bresp, m_bresp);
         if (m_rvalid) begin
            chk("rdata", rdata, m_rdata);
            chk("rresp", rresp, m_rresp);
         end
         chk("reg_wr", reg_wr, m_reg_wr);
         for (int i = 0; i < 16; i++) chk("reg_out", reg_out[i*32 +: 32], m_regs[i]);
      end
   end

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = (32'($urandom_range(0, 19)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) a = a | 32'h8000_0000;
      return a;
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_awready", awready, 1'b1);
      chk("rst_wready",  wready,  1'b1);
      chk("rst_arready", arready, 1'b1);
      chk("rst_bvalid",  bvalid,  1'b0);
      chk("rst_rvalid",  rvalid,  1'b0);
      chk("rst_rdata",   rdata,   32'h0);
      chk("rst_bresp",   bresp,   2'b00);
      chk("rst_rresp",   rresp,   2'b00);
      chk("rst_reg_out", reg_out[63:0], 64'h0);

      // write to reg 5 first so the mid-write reset has something to clear
      awvalid = 1; awaddr = 32'h14; wvalid = 1; wdata = 32'hCAFE_0001; wstrb = 4'hF;
      @(negedge clk); awvalid = 0; wvalid = 0;
      @(negedge clk);
      // reset arriving with AW held and W still missing
      awvalid = 1; awaddr = 32'h8;
      @(negedge clk); awvalid = 0;
      #2 rst = 1'b1;
      #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_bvalid",  bvalid, 1'b0);
      chk("midrst_reg5",    reg_out[191:160], 32'h0);
      chk("midrst_awready", awready, 1'b1);
      chk("midrst_wready",  wready, 1'b1);

      // same-cycle AW/W to 0x04
      awvalid = 1; awaddr = 32'h4; wvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF;
      @(negedge clk); awvalid = 0; wvalid = 0;
      chk("wr1_bvalid", bvalid, 1'b1);
      chk("wr1_bresp",  bresp, 2'b00);
      chk("wr1_reg1",   reg_out[63:32], 32'hDEADBEEF);
      chk("wr1_reg_wr", reg_wr, 16'h0002);
      @(negedge clk);
      chk("wr1_reg_wr_end", reg_wr, 16'h0000);
      chk("wr1_bvalid_end", bvalid, 1'b0);
      arvalid = 1; araddr = 32'h4;
      @(negedge clk); arvalid = 0;
      chk("rd1_rvalid", rvalid, 1'b1);
      chk("rd1_rdata",  rdata, 32'hDEADBEEF);
      @(negedge clk);

      // W three cycles ahead of AW, single byte lane
      awvalid = 1; awaddr = 32'hC; wvalid = 1; wdata = 32'h11223344; wstrb = 4'hF;
      @(negedge clk); awvalid = 0; wvalid = 0;
      @(negedge clk);
      wvalid = 1; wdata = 32'h0000AB00; wstrb = 4'b0010;
      @(negedge clk); wvalid = 0;
      repeat (2) @(negedge clk);
      awvalid = 1; awaddr = 32'hC;
      @(negedge clk); awvalid = 0;
      chk("wfirst_bvalid", bvalid, 1'b1);
      chk("wfirst_reg3",   reg_out[127:96], 32'h1122AB44);
      @(negedge clk);
      chk("wfirst_single_bresp", bvalid, 1'b0);

      // write response back-pressure
      bready = 0;
      awvalid = 1; awaddr = 32'h14; wvalid = 1; wdata = 32'h12345678; wstrb = 4'hF;
      @(negedge clk); awvalid = 0; wvalid = 0;
      for (int i = 0; i < 5; i++) begin
         chk("bstall_bvalid",  bvalid, 1'b1);
         chk("bstall_awready", awready, 1'b0);
         chk("bstall_wready",  wready, 1'b0);
         @(negedge clk);
      end
      bready = 1;
      @(negedge clk);
      chk("bstall_release", bvalid, 1'b0);

      // read data back-pressure
      rready = 0;
      arvalid = 1; araddr = 32'h14;
      @(negedge clk); arvalid = 0;
      for (int i = 0; i < 5; i++) begin
         chk("rstall_rvalid",  rvalid, 1'b1);
         chk("rstall_rdata",   rdata, 32'h12345678);
         chk("rstall_arready", arready, 1'b0);
         @(negedge clk);
      end
      rready = 1;
      @(negedge clk);
      chk("rstall_release", rvalid, 1'b0);

      // read and write commit to reg 2 on the same edge
      awvalid = 1; awaddr = 32'h8; wvalid = 1; wdata = 32'h55; wstrb = 4'hF;
      @(negedge clk); awvalid = 0; wvalid = 0;
      @(negedge clk);
      awvalid = 1; awaddr = 32'h8; wvalid = 1; wdata = 32'hAA; arvalid = 1; araddr = 32'h8;
      @(negedge clk); awvalid = 0; wvalid = 0; arvalid = 0;
      chk("rw_same_rdata_old", rdata, 32'h55);
      chk("rw_same_reg2",      reg_out[95:64], 32'hAA);
      @(negedge clk);
      arvalid = 1; araddr = 32'h8;
      @(negedge clk); arvalid = 0;
      chk("rw_same_rdata_new", rdata, 32'hAA);
      @(negedge clk);

      // out-of-range address
      awvalid = 1; awaddr = 32'h40; wvalid = 1; wdata = 32'hFFFFFFFF; wstrb = 4'hF;
      arvalid = 1; araddr = 32'h40;
      @(negedge clk); awvalid = 0; wvalid = 0; arvalid = 0;
      chk("oor_bresp",  bresp, EXP_OOR);
      chk("oor_rresp",  rresp, EXP_OOR);
      chk("oor_rdata",  rdata, 32'h0);
      chk("oor_reg_wr", reg_wr, 16'h0);
      chk("oor_reg1",   reg_out[63:32], 32'hDEADBEEF);
      chk("oor_reg0",   reg_out[31:0], 32'h0);
      @(negedge clk);

      // randomized traffic, AXI-legal: valid and payload held until accepted
      for (int c = 0; c < 3000; c++) begin
         if (awvalid && f_aw) awvalid = 0;
         if (!awvalid && $urandom_range(0, 2) == 0) begin
            awvalid = 1; awaddr = rand_addr();
         end
         if (wvalid && f_w) wvalid = 0;
         if (!wvalid && $urandom_range(0, 2) == 0) begin
            wvalid = 1; wdata = $urandom; wstrb = 4'($urandom_range(0, 15));
         end
         if (arvalid && f_ar) arvalid = 0;
         if (!arvalid && $urandom_range(0, 2) == 0) begin
            arvalid = 1; araddr = rand_addr();
         end
         bready = ($urandom_range(0, 3) != 0);
         rready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
      end
      if (awvalid && f_aw) awvalid = 0;
      if (wvalid && f_w) wvalid = 0;
      if (arvalid && f_ar) arvalid = 0;
      bready = 1; rready = 1;
      repeat (10) @(negedge clk);
      awvalid = 0; wvalid = 0; arvalid = 0;
      repeat (5) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
